// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO reader: FSM encoding and default sizing.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned DEF_BURST_LEN  = 4;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port and downstream valid/ready port of the FIFO reader.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  FIFO_empty;
    logic                  FIFO_almost_empty;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  FIFO_data_out, FIFO_empty, FIFO_almost_empty, out_ready,
        output read_enable, out_data, out_valid
    );

    modport slave (
        output FIFO_data_out, FIFO_empty, FIFO_almost_empty, out_ready,
        input  read_enable, out_data, out_valid
    );
endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer with registered valid/data; head entry drives the output.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occ
);
    logic [DATA_WIDTH-1:0] head_q, tail_q, head_d, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  valid_q;
    logic                  pop;

    assign pop = valid_q && ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = in_data;
                else               tail_d = in_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) head_d = tail_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // simultaneous push and pop keeps occupancy and order
                if (occ_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign valid    = valid_q;
    assign out_data = head_q;
    assign occ      = occ_q;
endmodule

// File: rtl/fifo_reader.sv
// Burst/drain reader that pulls words from a FIFO into a backpressured stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          flush,
    fifo_reader_if.master fif,
    output logic          busy,
    output logic [15:0]   word_count
);
    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t     state, next_state;
    logic [3:0] burst_cnt;
    logic       in_flight;
    logic [1:0] occ;
    logic       rd_en;
    logic       accept;

    // Reads are throttled so buffered plus outstanding words never exceed two.
    always_comb begin
        rd_en = 1'b0;
        if ((state == BURST && burst_cnt < BURST_MAX) || state == DRAIN)
            rd_en = Enable && !fif.FIFO_empty && ((3'(occ) + 3'(in_flight)) < 3'd2);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Enable && flush)
                    next_state = DRAIN;
                else if (Enable && !fif.FIFO_almost_empty && !fif.FIFO_empty)
                    next_state = BURST;
            end
            BURST: begin
                if (flush)
                    next_state = DRAIN;
                else if (fif.FIFO_empty || (burst_cnt + 4'(rd_en) == BURST_MAX))
                    next_state = IDLE;
            end
            DRAIN: begin
                if (fif.FIFO_empty && !in_flight)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            in_flight  <= 1'b0;
            word_count <= '0;
        end else begin
            state     <= next_state;
            in_flight <= rd_en;
            if (state == BURST && next_state == BURST)
                burst_cnt <= burst_cnt + 4'(rd_en);
            else
                burst_cnt <= '0;
            if (accept)
                word_count <= word_count + 16'd1;
        end
    end

    assign accept          = fif.out_valid && fif.out_ready;
    assign fif.read_enable = rd_en;
    assign busy            = (state != IDLE) || in_flight || (occ != 2'd0);

    fifo_reader_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk      (clk),
        .rst      (Reset),
        .push     (in_flight),
        .in_data  (fif.FIFO_data_out),
        .ready    (fif.out_ready),
        .valid    (fif.out_valid),
        .out_data (fif.out_data),
        .occ      (occ)
    );
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: array-backed FIFO model, in-order scoreboard, directed and random phases.
module tb_fifo_reader;
    localparam int unsigned DW = 12;
    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        flush;
    logic        busy;
    logic [15:0] word_count;

    fifo_reader_if #(.DATA_WIDTH(DW)) fif ();

    fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .flush      (flush),
        .fif        (fif),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    int unsigned   wr_ptr = 0, rd_ptr = 0, ae_thresh = 0;
    int unsigned   exp_idx = 0, n_reads = 0, n_acc = 0;
    int            checks = 0, failures = 0;
    logic          stall = 1'b0;
    logic [DW-1:0] stall_data = '0;

    assign fif.FIFO_empty        = (wr_ptr == rd_ptr);
    assign fif.FIFO_almost_empty = ((wr_ptr - rd_ptr) <= ae_thresh);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: word appears on FIFO_data_out after the edge that samples read_enable.
    always @(posedge clk) begin
        if (fif.read_enable && wr_ptr != rd_ptr) begin
            fif.FIFO_data_out <= mem[rd_ptr[9:0]];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (Reset) begin
            exp_idx = rd_ptr;
            n_acc   = 0;
            stall   = 1'b0;
        end else begin
            if (fif.read_enable) begin
                n_reads++;
                check("rd_nonempty", 32'(fif.FIFO_empty), 0);
            end
            if (stall) begin
                check("hold_valid", 32'(fif.out_valid), 1);
                check("hold_data", 32'(fif.out_data), 32'(stall_data));
            end
            if (fif.out_valid && fif.out_ready) begin
                check("out_data", 32'(fif.out_data), 32'(mem[exp_idx[9:0]]));
                exp_idx++;
                n_acc++;
            end
            stall      = fif.out_valid && !fif.out_ready;
            stall_data = fif.out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(logic [DW-1:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_done(string tag, int unsigned budget);
        bit ok = 1'b0;
        for (int unsigned k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && !flush && (fif.FIFO_empty || fif.FIFO_almost_empty)) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(ok), 1);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int unsigned r0, a0, lat;
        logic [DW-1:0] preload [5];
        preload = '{12'hFFF, 12'hACF, 12'h1B7, 12'hB08, 12'h611};

        Reset = 1'b1; Enable = 1'b0; flush = 1'b0; fif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd", 32'(fif.read_enable), 0);
        check("rst_valid", 32'(fif.out_valid), 0);
        check("rst_data", 32'(fif.out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wc", 32'(word_count), 0);
        step();
        Reset = 1'b0;
        step();

        // preloaded sequence delivered in order, with first-word latency
        ae_thresh = 0;
        foreach (preload[i]) push_word(preload[i]);
        fif.out_ready = 1'b1;
        Enable = 1'b1;
        lat = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (fif.out_valid) break;
        end
        check("first_lat", lat, 4);
        wait_done("seq5", 200);
        check("seq5_cnt", n_acc, 5);
        check("seq5_wc", 32'(word_count), 5);
        check("seq5_all", exp_idx, wr_ptr);

        // level at threshold: nothing read
        ae_thresh = 2;
        push_word(12'h0A5);
        push_word(12'h35C);
        r0 = n_reads;
        repeat (20) @(negedge clk);
        check("ae_reads", n_reads - r0, 0);
        check("ae_busy", 32'(busy), 0);
        step();

        // flush drains below threshold
        a0 = n_acc;
        flush = 1'b1;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc - a0 >= 2) break;
        end
        check("flush_cnt", n_acc - a0, 2);
        step();
        flush = 1'b0;
        wait_done("flush", 100);
        check("flush_empty", 32'(fif.FIFO_empty), 1);
        check("flush_wc", 32'(word_count), 32'(n_acc));

        // burst limit: threshold 4 stops after one burst, then threshold 2 allows the next
        ae_thresh = 4;
        for (int unsigned i = 0; i < 8; i++) push_word(DW'($urandom));
        r0 = n_reads;
        wait_done("burst1", 200);
        check("burst1_reads", n_reads - r0, BL);
        check("burst1_level", wr_ptr - rd_ptr, 4);
        ae_thresh = 2;
        r0 = n_reads;
        wait_done("burst2", 200);
        check("burst2_reads", n_reads - r0, BL);
        check("burst2_all", exp_idx, wr_ptr);

        // backpressure
        ae_thresh = 0;
        fif.out_ready = 1'b0;
        for (int unsigned i = 0; i < 6; i++) push_word(DW'($urandom));
        r0 = n_reads;
        repeat (10) @(negedge clk);
        check("bp_reads", 32'((n_reads - r0) >= 1 && (n_reads - r0) <= 2), 1);
        check("bp_valid", 32'(fif.out_valid), 1);
        step();
        fif.out_ready = 1'b1;
        wait_done("bp", 300);
        check("bp_all", exp_idx, wr_ptr);

        // randomized traffic
        for (int unsigned c = 0; c < 600; c++) begin
            fif.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) Enable = ~Enable;
            if ($urandom_range(0, 31) == 0) ae_thresh = $urandom_range(0, 3);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0 && wr_ptr < 900) push_word(DW'($urandom));
            step();
        end
        Enable = 1'b1; fif.out_ready = 1'b1; flush = 1'b0; ae_thresh = 0;
        wait_done("rand", 2000);
        check("rand_all", exp_idx, wr_ptr);
        check("rand_wc", 32'(word_count), 32'(n_acc));

        // reset mid-burst
        fif.out_ready = 1'b0;
        for (int unsigned i = 0; i < 8; i++) push_word(DW'($urandom));
        r0 = n_reads;
        for (int unsigned i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_reads - r0 >= 2) break;
        end
        step();
        Reset = 1'b1;
        #1;
        check("mrst_rd", 32'(fif.read_enable), 0);
        check("mrst_valid", 32'(fif.out_valid), 0);
        check("mrst_data", 32'(fif.out_data), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_wc", 32'(word_count), 0);
        fif.out_ready = 1'b1;
        step();
        step();
        Reset = 1'b0;
        @(negedge clk);
        check("post_rst_rd", 32'(fif.read_enable), 0);
        check("post_rst_wc", 32'(word_count), 0);
        step();
        wait_done("post_rst", 300);
        check("post_rst_all", exp_idx, wr_ptr);
        check("post_rst_wc2", 32'(word_count), 32'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
